card_selector: RTL

- Front-end stage directly upstream of gameplay_sm; it drives Select, CardSelectData and CardSelectLoc.
- Debounces five player buttons and moves a cursor over the 4x4 board.
- Keeps a shadow copy of the board by snooping gameplay_sm's write bus (WriteEnable/dataLoc/dataOut).
- Raises Select only when the card under the cursor is hidden and selection is enabled, so face-up, removed or unwritten cards can never be picked.

---
 rtl/gameplay_pkg.sv | 33 +++
 rtl/card_selector_if.sv | 31 +++
 rtl/card_selector_debouncer.sv | 58 +++++
 rtl/card_selector.sv | 118 +++++++++++
 4 files changed

// File: rtl/gameplay_pkg.sv
// Shared constants for the memory-game datapath: board geometry, card status
// encoding and the card_selector state machine encoding.
package gameplay_pkg;

  localparam int BOARD_SIZE = 16;
  localparam int LOC_W      = 4;
  localparam int DATA_W     = 6;

  localparam logic [1:0] ST_FACEUP  = 2'b00;
  localparam logic [1:0] ST_HIDDEN  = 2'b01;
  localparam logic [1:0] ST_REMOVED = 2'b10;
  localparam logic [1:0] ST_EMPTY   = 2'b11;

  localparam logic [DATA_W-1:0] ENTRY_EMPTY = {ST_EMPTY, 4'b0000};

  localparam int NUM_BTN = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_SELECT = 4;

  typedef enum logic [1:0] {
    SEL_IDLE     = 2'd0,
    SEL_HELD     = 2'd1,
    SEL_WAIT_REL = 2'd2
  } sel_state_t;

  function automatic logic [1:0] entry_status(input logic [DATA_W-1:0] entry);
    return entry[DATA_W-1:DATA_W-2];
  endfunction

endpackage

// File: rtl/card_selector_if.sv
// Button, board-snoop and selection signals between card_selector and its
// surroundings (buttons / gameplay_sm).
interface card_selector_if;
  import gameplay_pkg::*;

  logic              BtnUp;
  logic              BtnDown;
  logic              BtnLeft;
  logic              BtnRight;
  logic              BtnSelect;
  logic              SelEnable;
  logic              WriteEnable;
  logic [LOC_W-1:0]  dataLoc;
  logic [DATA_W-1:0] dataOut;
  logic [LOC_W-1:0]  CardSelectLoc;
  logic [DATA_W-1:0] CardSelectData;
  logic              Select;

  modport master (
    output BtnUp, BtnDown, BtnLeft, BtnRight, BtnSelect,
    output SelEnable, WriteEnable, dataLoc, dataOut,
    input  CardSelectLoc, CardSelectData, Select
  );

  modport slave (
    input  BtnUp, BtnDown, BtnLeft, BtnRight, BtnSelect,
    input  SelEnable, WriteEnable, dataLoc, dataOut,
    output CardSelectLoc, CardSelectData, Select
  );

endinterface

// File: rtl/card_selector_debouncer.sv
// One button channel: 2-FF synchronizer, stable-count debouncer and a
// one-cycle pulse on the debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             level_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Flip the debounced level only after the input differs for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b0;
    end else if (sync2_r == level_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= ~level_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Delayed level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_r <= 1'b0;
    end else begin
      level_d_r <= level_r;
    end
  end

  assign level = level_r;
  assign press = level_r & ~level_d_r;

endmodule

// File: rtl/card_selector.sv
// Debounced cursor control over the 4x4 board with a snooped shadow copy of
// the board; requests selection only of hidden cards.
module card_selector
  import gameplay_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic           Clk,
  input  logic           Reset,
  card_selector_if.slave bus
);

  logic [NUM_BTN-1:0] raw_s;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] press_s;

  logic [LOC_W-1:0]  cursor_r;
  logic [DATA_W-1:0] shadow_r [BOARD_SIZE];
  sel_state_t        state_r;
  sel_state_t        state_next_s;
  logic              select_r;
  logic              select_next_s;
  logic              accept_s;

  assign raw_s = {bus.BtnSelect, bus.BtnRight, bus.BtnLeft, bus.BtnDown, bus.BtnUp};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk  (Clk),
      .rst_n(Reset),
      .raw  (raw_s[i]),
      .level(level_s[i]),
      .press(press_s[i])
    );
  end

  // Cursor motion: single highest-priority direction, frozen while Select is high
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cursor_r <= {LOC_W{1'b0}};
    end else if (!select_r) begin
      if (press_s[BTN_UP]) begin
        cursor_r[3:2] <= cursor_r[3:2] - 2'd1;
      end else if (press_s[BTN_DOWN]) begin
        cursor_r[3:2] <= cursor_r[3:2] + 2'd1;
      end else if (press_s[BTN_LEFT]) begin
        cursor_r[1:0] <= cursor_r[1:0] - 2'd1;
      end else if (press_s[BTN_RIGHT]) begin
        cursor_r[1:0] <= cursor_r[1:0] + 2'd1;
      end
    end
  end

  // Shadow board tracks every gameplay_sm board write
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < BOARD_SIZE; i++) begin
        shadow_r[i] <= ENTRY_EMPTY;
      end
    end else if (bus.WriteEnable) begin
      shadow_r[bus.dataLoc] <= bus.dataOut;
    end
  end

  // Registered array means acceptance always sees the pre-write entry
  assign accept_s = bus.SelEnable && (entry_status(shadow_r[cursor_r]) == ST_HIDDEN);

  // Selection state and registered Select level
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r  <= SEL_IDLE;
      select_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      select_r <= select_next_s;
    end
  end

  // Next-state decision
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SEL_IDLE: begin
        if (press_s[BTN_SELECT]) begin
          state_next_s = accept_s ? SEL_HELD : SEL_WAIT_REL;
        end else begin
          state_next_s = SEL_IDLE;
        end
      end
      SEL_HELD, SEL_WAIT_REL: begin
        if (!level_s[BTN_SELECT]) begin
          state_next_s = SEL_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = SEL_IDLE;
    endcase
  end

  // Select is high exactly while the machine sits in HELD
  always_comb begin
    select_next_s = 1'b0;
    case (state_next_s)
      SEL_HELD: select_next_s = 1'b1;
      default:  select_next_s = 1'b0;
    endcase
  end

  assign bus.CardSelectLoc  = cursor_r;
  assign bus.CardSelectData = shadow_r[cursor_r];
  assign bus.Select         = select_r;

endmodule
